// File: rtl/muldiv_ctrl.sv
// Sequencer between the control unit and the multiplier/divider.
// Launches one unit, waits for completion or timeout, then updates HI/LO.
module muldiv_ctrl #(
   parameter int TIMEOUT = 40
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        Start,
   input  logic        Op,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic [31:0] OpA,
   output logic [31:0] OpB,
   output logic        DivStart,
   input  logic        DivStop,
   input  logic        DivZero,
   input  logic [31:0] DivHI,
   input  logic [31:0] DivLO,
   output logic        MultStart,
   input  logic        MultStop,
   input  logic [31:0] MultHI,
   input  logic [31:0] MultLO,
   output logic [31:0] HI,
   output logic [31:0] LO,
   output logic        Busy,
   output logic        Done,
   output logic        ZeroDiv,
   output logic        Timeout
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LAUNCH,
      S_WAIT,
      S_WRITE,
      S_EXC
   } state_t;

   localparam logic [5:0] TO_LAST = 6'(TIMEOUT - 1);

   state_t      state_q, state_d;
   logic [5:0]  cnt_q, cnt_d;
   logic        op_q;
   logic [31:0] opa_q, opb_q, hi_q, lo_q;
   logic        zero_q, zero_d, tout_q, tout_d;
   logic        busy_q, done_q, dstart_q, mstart_q;
   logic        accept, wr_div, wr_mult;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      zero_d  = zero_q;
      tout_d  = tout_q;
      accept  = 1'b0;
      wr_div  = 1'b0;
      wr_mult = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (Start) begin
               state_d = S_LAUNCH;
               accept  = 1'b1;
            end
         end
         S_LAUNCH: begin
            state_d = S_WAIT;
            cnt_d   = '0;
         end
         S_WAIT: begin
            cnt_d = cnt_q + 6'd1;
            // divide-by-zero beats completion, completion beats timeout
            if (op_q && DivZero) begin
               state_d = S_EXC;
               zero_d  = 1'b1;
            end else if (op_q && DivStop) begin
               state_d = S_WRITE;
               wr_div  = 1'b1;
            end else if (!op_q && MultStop) begin
               state_d = S_WRITE;
               wr_mult = 1'b1;
            end else if (cnt_q == TO_LAST) begin
               state_d = S_EXC;
               tout_d  = 1'b1;
            end
         end
         S_WRITE: state_d = S_IDLE;
         S_EXC: begin
            state_d = S_IDLE;
            zero_d  = 1'b0;
            tout_d  = 1'b0;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         op_q     <= 1'b0;
         opa_q    <= '0;
         opb_q    <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         zero_q   <= 1'b0;
         tout_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         dstart_q <= 1'b0;
         mstart_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         zero_q   <= zero_d;
         tout_q   <= tout_d;
         busy_q   <= (state_d != S_IDLE);
         done_q   <= (state_d == S_WRITE);
         dstart_q <= accept && Op;
         mstart_q <= accept && !Op;
         if (accept) begin
            op_q  <= Op;
            opa_q <= A;
            opb_q <= B;
         end
         if (wr_div) begin
            hi_q <= DivHI;
            lo_q <= DivLO;
         end else if (wr_mult) begin
            hi_q <= MultHI;
            lo_q <= MultLO;
         end
      end
   end

   assign OpA       = opa_q;
   assign OpB       = opb_q;
   assign HI        = hi_q;
   assign LO        = lo_q;
   assign Busy      = busy_q;
   assign Done      = done_q;
   assign DivStart  = dstart_q;
   assign MultStart = mstart_q;
   assign ZeroDiv   = zero_q;
   assign Timeout   = tout_q;

endmodule

// File: doc/muldiv_ctrl.md
MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 Parameter: TIMEOUT, default 40, meaning max WAIT cycles before abort (range 2..63).
REQ-002 clk  in  1  rising-edge system clock.
REQ-003 reset  in  1  asynchronous, active-low; 0 forces reset state immediately.
REQ-004 Start  in  1  operation request from control unit; sampled only in IDLE.
REQ-005 Op  in  1  0 = MULT, 1 = DIV; sampled with Start.
REQ-006 A, B  in  32 each  operands; sampled with Start.
REQ-007 OpA, OpB  out  32 each  latched operands driven to both arithmetic units.
REQ-008 DivStart  out  1  one-cycle launch pulse to divider (its CtrlDiv).
REQ-009 DivStop, DivZero  in  1 each  divider completion / divide-by-zero flags.
REQ-010 DivHI, DivLO  in  32 each  divider results.
REQ-011 MultStart  out  1  one-cycle launch pulse to multiplier.
REQ-012 MultStop  in  1  multiplier completion; MultHI, MultLO  in  32 each  results.
REQ-013 HI, LO  out  32 each  architectural HI/LO registers.
REQ-014 Busy  out  1  high whenever state != IDLE; control unit stalls on it.
REQ-015 Done, ZeroDiv, Timeout  out  1 each  one-cycle completion / exception pulses.

Function
REQ-016 FSM states: IDLE, LAUNCH, WAIT, WRITE, EXC; encoding free.
REQ-017 IDLE, Start=1 at edge k: latch Op, A->OpA, B->OpB; state LAUNCH at k.
REQ-018 IDLE, Start=0: hold; all pulse outputs 0.
REQ-019 LAUNCH: drive DivStart=1 (Op=1) or MultStart=1 (Op=0) for exactly this one cycle, other start 0; clear WAIT counter; next state WAIT.
REQ-020 WAIT: 6-bit counter increments each cycle, starting 0 on first WAIT cycle.
REQ-021 WAIT, Op=1, DivZero=1: next state EXC with zero flag set; HI/LO unchanged.
REQ-022 WAIT, Op=1, DivStop=1, DivZero=0: on that edge HI<=DivHI, LO<=DivLO; next state WRITE.
REQ-023 WAIT, Op=0, MultStop=1: on that edge HI<=MultHI, LO<=MultLO; next state WRITE.
REQ-024 Completion flags of the unit not selected by latched Op are ignored; all Stop/Zero inputs ignored outside WAIT.
REQ-025 WAIT, no completion, counter == TIMEOUT-1: next state EXC with timeout flag set; HI/LO unchanged.
REQ-026 Priority in the same WAIT cycle: DivZero > Stop > timeout.
REQ-027 WRITE: Done=1 for this one cycle; next state IDLE.
REQ-028 EXC: ZeroDiv=1 or Timeout=1 (per flag) for this one cycle, never both; next state IDLE; flags cleared.
REQ-029 Start while Busy is ignored (no queuing); OpA/OpB stable from LAUNCH through return to IDLE.
REQ-030 Latency: Start sampled at edge k -> launch pulse during cycle k..k+1 -> Done pulse one cycle after the Stop-sampling edge.
REQ-031 Back-to-back: Start may be accepted in the IDLE cycle immediately following WRITE/EXC.

Reset
REQ-032 reset=0 asynchronously sets state IDLE, HI=LO=0, OpA=OpB=0, counter=0, latched Op=0, all flags cleared.
REQ-033 Outputs during reset: Busy=0, DivStart=MultStart=0, Done=ZeroDiv=Timeout=0.
REQ-034 Reset mid-operation aborts with no pulse and no HI/LO update; late Stop from a unit after release is ignored (IDLE).
REQ-035 First Start accepted on the first rising edge after reset deasserts.

Verification
REQ-036 DIV A=7 B=2, divider model asserts DivStop with DivLO=3 DivHI=1 after 32 cycles -> one DivStart pulse, Busy high throughout, LO=3 HI=1, one Done pulse, Busy low next cycle.
REQ-037 DIV A=5 B=0, model asserts DivZero 1 cycle after DivStart -> one ZeroDiv pulse, no Done, HI/LO keep prior values.
REQ-038 MULT A=0xFFFFFFFF B=2, model MultStop with MultHI=0xFFFFFFFF MultLO=0xFFFFFFFE -> MultStart pulse only, DivStart never high, HI/LO updated, Done pulse.
REQ-039 Start re-pulsed with new operands during WAIT -> ignored; OpA/OpB unchanged; exactly one Done.
REQ-040 TIMEOUT=40, model never completes -> Timeout pulse exactly after 40 WAIT cycles, HI/LO unchanged, IDLE next.
REQ-041 reset=0 asserted mid-WAIT of a DIV, then DivStop arrives after release -> HI=LO=0, no Done, Busy=0, state IDLE.
